// File: rtl/load_store_ctrl_pkg.sv
// load_store_ctrl_pkg
// Shared types and constants for the load/store controller: FSM state
// encoding, access size encodings, the word-address slice of the byte
// address, and small helpers for alignment decisions.
package load_store_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // Memory word address is byte address [17:2]; upper bits are ignored.
  localparam int WADDR_MSB = 17;
  localparam int WADDR_LSB = 2;
  localparam int WADDR_W   = WADDR_MSB - WADDR_LSB + 1;

  // Size code 11 behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    return (size == 2'b11) ? SIZE_W : size;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_H:  return lo[0];
      SIZE_W:  return |lo;
      default: return 1'b0;
    endcase
  endfunction

  // Forces the low address bits to the natural alignment of the access.
  function automatic logic [1:0] align_lane(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SIZE_H:  return {lo[1], 1'b0};
      SIZE_W:  return 2'b00;
      default: return lo;
    endcase
  endfunction

endpackage

// File: rtl/load_store_ctrl_if.sv
// load_store_ctrl_if
// Bundles the core request/response handshake and the memory port.
//   slave  : controller view (takes requests, drives the memory port)
//   master : environment view (core plus memory)
// Signals:
//   req_valid/req_ready/req_we/req_addr/req_size/req_unsigned/req_wdata
//   resp_valid/resp_ready/resp_rdata/resp_err
//   wEn/address/write_data/read_data
interface load_store_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        wEn;
  logic [15:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport slave (
    input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    input  resp_ready, read_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output wEn, address, write_data
  );

  modport master (
    output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
    output resp_ready, read_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  wEn, address, write_data
  );
endinterface

// File: rtl/load_store_ctrl_lane_align.sv
// lane_align
// Combinational lane logic for sub-word accesses.
//   i_word     : word read from memory
//   i_lane     : byte lane (already naturally aligned)
//   i_size     : normalised access size (SIZE_B/SIZE_H/SIZE_W)
//   i_unsigned : zero-extend loads when 1, sign-extend when 0
//   i_wdata    : right-aligned store data
//   o_load     : extracted and extended load value
//   o_merged   : i_word with the addressed lane(s) replaced by i_wdata
module lane_align
  import load_store_ctrl_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_lane,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_merged
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte   = i_word[{i_lane, 3'b000} +: 8];
    w_half   = i_lane[1] ? i_word[31:16] : i_word[15:0];
    o_load   = i_word;
    o_merged = i_wdata;
    case (i_size)
      SIZE_B: begin
        o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
        o_merged = i_word;
        o_merged[{i_lane, 3'b000} +: 8] = i_wdata[7:0];
      end
      SIZE_H: begin
        o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
        o_merged = i_word;
        if (i_lane[1]) o_merged[31:16] = i_wdata[15:0];
        else           o_merged[15:0]  = i_wdata[15:0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_ctrl.sv
// load_store_ctrl
// Sequences core loads/stores onto a single-port word memory. Sub-word
// stores are done as read-modify-write.
// Parameters:
//   MEM_LAT : cycles from address to valid read_data (1..4)
// Ports:
//   clock, reset_n (async active-low)
//   bus     : load_store_ctrl_if.slave (core handshake + memory port)
// Build option:
//   MISALIGN_TRAP_EN : misaligned half/word requests respond with resp_err=1
//                      and no memory access; otherwise low address bits are
//                      forced to natural alignment and resp_err is 0.
//
// state | meaning
// IDLE  | req_ready=1, waiting for a request
// RD    | address held, waiting MEM_LAT cycles for read_data
// WR    | wEn=1 for one cycle
// RESP  | response held until resp_ready
module load_store_ctrl
  import load_store_ctrl_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  load_store_ctrl_if.slave  bus
);

  localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

  state_t               r_state, w_next;
  logic                 r_we;
  logic                 r_unsigned;
  logic [1:0]           r_size;
  logic [1:0]           r_lane;
  logic [31:0]          r_wdata;
  logic [1:0]           r_lat_cnt;
  logic [WADDR_W-1:0]   r_address;
  logic [31:0]          r_write_data;
  logic [31:0]          r_resp_rdata;

  logic                 w_accept;
  logic [1:0]           w_size;
  logic [1:0]           w_lane;
  logic                 w_trap;
  logic                 w_rd_done;
  logic                 w_word_store;
  logic [31:0]          w_load;
  logic [31:0]          w_merged;
  logic                 w_unused_addr_hi;

  assign w_size       = norm_size(bus.req_size);
  assign w_lane       = align_lane(w_size, bus.req_addr[1:0]);
  assign w_accept     = (r_state == IDLE) && bus.req_valid;
  assign w_word_store = bus.req_we && (w_size == SIZE_W);
  assign w_rd_done    = (r_state == RD) && (r_lat_cnt == 2'd0);
  assign w_unused_addr_hi = ^bus.req_addr[31:WADDR_MSB+1];

`ifdef MISALIGN_TRAP_EN
  assign w_trap = misaligned(w_size, bus.req_addr[1:0]);
`else
  assign w_trap = 1'b0;
`endif

  lane_align u_lane_align (
    .i_word     (bus.read_data),
    .i_lane     (r_lane),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req_valid) begin
          if (w_trap)            w_next = RESP;
          else if (w_word_store) w_next = WR;
          else                   w_next = RD;
        end
      end
      RD:      if (w_rd_done) w_next = r_we ? WR : RESP;
      WR:      w_next = RESP;
      RESP:    if (bus.resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_we         <= 1'b0;
      r_unsigned   <= 1'b0;
      r_size       <= SIZE_B;
      r_lane       <= 2'd0;
      r_wdata      <= '0;
      r_lat_cnt    <= 2'd0;
      r_address    <= '0;
      r_write_data <= '0;
      r_resp_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_we       <= bus.req_we;
            r_unsigned <= bus.req_unsigned;
            r_size     <= w_size;
            r_lane     <= w_lane;
            r_wdata    <= bus.req_wdata;
            r_lat_cnt  <= LAT_LOAD;
            // A trapped request must not disturb the memory port.
            if (!w_trap) r_address <= bus.req_addr[WADDR_MSB:WADDR_LSB];
            if (!w_trap && w_word_store) r_write_data <= bus.req_wdata;
            if (w_trap) r_resp_rdata <= '0;
          end
        end
        RD: begin
          if (r_lat_cnt != 2'd0) r_lat_cnt <= r_lat_cnt - 2'd1;
          else if (r_we)         r_write_data <= w_merged;
          else                   r_resp_rdata <= w_load;
        end
        WR:      r_resp_rdata <= '0;
        default: ;
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic r_resp_err;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)      r_resp_err <= 1'b0;
    else if (w_accept) r_resp_err <= w_trap;
  end

  assign bus.resp_err = r_resp_err;
`else
  assign bus.resp_err = 1'b0;
`endif

  assign bus.req_ready  = (r_state == IDLE);
  assign bus.resp_valid = (r_state == RESP);
  assign bus.wEn        = (r_state == WR);
  assign bus.address    = r_address;
  assign bus.write_data = r_write_data;
  assign bus.resp_rdata = r_resp_rdata;

endmodule

// File: tb/tb_load_store_ctrl.sv
// tb_load_store_ctrl
// Drives load_store_ctrl through its interface with a behavioural memory
// (MEM_LAT=1, combinational read). Expected results come from a byte-level
// reference model of memory kept in this bench.
module tb_load_store_ctrl;
  import load_store_ctrl_pkg::*;

  localparam int MEM_LAT = 1;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  load_store_ctrl_if bus();

  load_store_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  logic [31:0] mem     [0:63];
  logic [31:0] ref_mem [0:63];
  int          n_wen = 0;
  logic [15:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  int n_checks = 0;
  int n_errors = 0;

  assign bus.read_data = mem[bus.address[5:0]];

  // Memory init and write port share one process.
  initial begin
    for (int i = 0; i < 64; i++) begin
      logic [31:0] v;
      v = $urandom;
      if (i == 4) v = 32'h8899AABB;
      mem[i]     = v;
      ref_mem[i] = v;
    end
    forever begin
      @(posedge clock);
      if (bus.wEn === 1'b1) begin
        mem[bus.address[5:0]] <= bus.write_data;
        n_wen      = n_wen + 1;
        last_waddr = bus.address;
        last_wdata = bus.write_data;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes_of(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit ref_misaligned(input logic [1:0] size, input int lo);
    return (lo % nbytes_of(size)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] word, input int lo,
                                           input logic [1:0] size, input bit uns);
    int nb, off;
    logic [63:0] v, span;
    nb   = nbytes_of(size);
    off  = lo - (lo % nb);
    span = 64'd1 << (8 * nb);
    v    = ({32'd0, word} >> (8 * off)) & (span - 64'd1);
    if (!uns && nb < 4 && v >= (span >> 1)) v = v - span;
    return v[31:0];
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] word, input int lo,
                                            input logic [1:0] size, input logic [31:0] wdata);
    int nb, off;
    logic [31:0] r;
    nb  = nbytes_of(size);
    off = lo - (lo % nb);
    r   = word;
    for (int b = 0; b < 4; b++)
      if (b >= off && b < off + nb) r[8*b +: 8] = wdata[8*(b-off) +: 8];
    return r;
  endfunction

  task automatic run_txn(input bit we, input logic [31:0] addr, input logic [1:0] size,
                         input bit uns, input logic [31:0] wdata, input int hold,
                         output logic [31:0] got_rdata);
    int idx, lo, cyc, exp_lat, exp_wen, wen0;
    bit trap;
    logic [31:0] exp_rdata, new_word;
    logic        exp_err;
    logic [15:0] addr0;
    idx = int'(addr[7:2]);
    lo  = int'(addr[1:0]);
`ifdef MISALIGN_TRAP_EN
    trap = !(size == 2'b00) && ref_misaligned(size, lo);
`else
    trap = 1'b0;
`endif
    new_word = ref_mem[idx];
    if (trap) begin
      exp_rdata = 32'd0; exp_err = 1'b1; exp_lat = 1; exp_wen = 0;
    end else if (we) begin
      exp_rdata = 32'd0; exp_err = 1'b0; exp_wen = 1;
      new_word  = ref_store(ref_mem[idx], lo, size, wdata);
      exp_lat   = (nbytes_of(size) == 4) ? 2 : 2 + MEM_LAT;
    end else begin
      exp_rdata = ref_load(ref_mem[idx], lo, size, uns); exp_err = 1'b0;
      exp_lat   = 1 + MEM_LAT; exp_wen = 0;
    end
    wen0  = n_wen;
    addr0 = bus.address;

    @(negedge clock);
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_addr     = addr;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_wdata    = wdata;
    check("req_ready_idle", bus.req_ready, 1);
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    cyc = 1;
    while (bus.resp_valid !== 1'b1 && cyc < 30) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("latency", cyc, exp_lat);
    check("rdata", bus.resp_rdata, exp_rdata);
    check("err", bus.resp_err, exp_err);
    got_rdata = bus.resp_rdata;

    for (int h = 0; h < hold; h++) begin
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_we    = 1'b1;
      bus.req_size  = SIZE_W;
      bus.req_addr  = 32'h0000_0004;
      bus.req_wdata = $urandom;
      @(posedge clock); #1;
      check("hold_valid", bus.resp_valid, 1);
      check("hold_rdata", bus.resp_rdata, exp_rdata);
      check("hold_ready", bus.req_ready, 0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clock); #1;
    bus.resp_ready = 1'b0;
    check("back_idle_ready", bus.req_ready, 1);
    check("back_idle_valid", bus.resp_valid, 0);
    check("wen_pulses", n_wen - wen0, exp_wen);
    if (exp_wen == 1) begin
      ref_mem[idx] = new_word;
      check("wr_addr", last_waddr, idx);
      check("wr_data", last_wdata, new_word);
    end
    if (trap) check("trap_addr_hold", bus.address, addr0);
    check("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, r;
    int wen0;
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = '0;
    bus.req_size     = SIZE_B;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    check("rst_wen", bus.wEn, 0);
    check("rst_address", bus.address, 0);
    check("rst_wdata", bus.write_data, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_rdata", bus.resp_rdata, 0);
    check("rst_resp_err", bus.resp_err, 0);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rst_ready", bus.req_ready, 1);

    run_txn(1'b0, 32'h10, SIZE_W, 1'b0, 32'h0, 0, rd);
    check("word_ld_const", rd, 32'h8899AABB);
    run_txn(1'b0, 32'h12, SIZE_B, 1'b0, 32'h0, 0, rd);
    check("sbyte_ld_const", rd, 32'hFFFFFF99);
    run_txn(1'b0, 32'h12, SIZE_B, 1'b1, 32'h0, 0, rd);
    check("ubyte_ld_const", rd, 32'h00000099);
    run_txn(1'b0, 32'h11, SIZE_W, 1'b0, 32'h0, 0, rd);
`ifdef MISALIGN_TRAP_EN
    check("misalign_const", rd, 32'h0);
`else
    check("misalign_const", rd, 32'h8899AABB);
`endif
    run_txn(1'b0, 32'h10, SIZE_W, 1'b0, 32'h0, 5, rd);
    check("hold_ld_const", rd, 32'h8899AABB);
    run_txn(1'b1, 32'h12, SIZE_H, 1'b0, 32'h0000_1234, 0, rd);
    check("hstore_addr_const", last_waddr, 16'd4);
    check("hstore_data_const", last_wdata, 32'h1234AABB);
    run_txn(1'b0, 32'h10, SIZE_W, 1'b0, 32'h0, 0, rd);
    check("after_hstore_const", rd, 32'h1234AABB);

    // Reset during the read phase of a byte store.
    wen0 = n_wen;
    @(negedge clock);
    bus.req_valid    = 1'b1;
    bus.req_we       = 1'b1;
    bus.req_addr     = 32'h13;
    bus.req_size     = SIZE_B;
    bus.req_unsigned = 1'b0;
    bus.req_wdata    = 32'h55;
    @(posedge clock); #1;
    bus.req_valid = 1'b0;
    check("rmw_in_rd_ready", bus.req_ready, 0);
    #2 reset_n = 1'b0;
    #1;
    check("rmw_rst_wen", bus.wEn, 0);
    check("rmw_rst_address", bus.address, 0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    check("rmw_rel_ready", bus.req_ready, 1);
    repeat (3) @(posedge clock);
    #1;
    check("rmw_rel_valid", bus.resp_valid, 0);
    check("rmw_no_wen", n_wen - wen0, 0);
    check("rmw_mem_kept", mem[4], 32'h1234AABB);

    for (int t = 0; t < 150; t++) begin
      r = $urandom;
      run_txn(1'($urandom_range(0, 1)),
              {r[31:18], 10'd0, 6'($urandom_range(0, 7)), 2'($urandom_range(0, 3))},
              2'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)),
              $urandom,
              $urandom_range(0, 2),
              rd);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
